i2c_master_tx: RTL and testbench

- Bus-side counterpart of the instruction decoder's I2C control outputs.
- Consumes the one-cycle start, stop and send-byte command pulses, and an 8-bit data operand, from the core.
- Drives the SCL/SDA lines of the OLED I2C bus as an open-drain, write-only master.
- Samples the slave ACK and reports busy, done and error status back to the core.

---
 rtl/i2c_master_tx.sv | 170 +++++++++++++++++
 tb/tb_i2c_master_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// Write-only open-drain I2C master: turns the core's start/send/stop pulses into
// SCL/SDA quarter-period waveforms and reports busy, done, ACK and command errors.
module i2c_master_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_i2c_start,
    input  logic       i_i2c_stop,
    input  logic       i_sendi2c,
    input  logic [7:0] i_data,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_cmd_err,
    output logic       o_bus_owned
);

    typedef enum logic [2:0] {IDLE, HOLD, START, BIT, ACK, STOP} state_t;

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [1:0]    quarter, quarter_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          ack_err_n, owned_n, done_n, cmd_err_n, busy_n;
    logic          scl_n, sda_n;
    logic          tick;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            div         <= '0;
            quarter     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_scl       <= 1'b1;
            o_sda       <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_ack_err   <= 1'b0;
            o_cmd_err   <= 1'b0;
            o_bus_owned <= 1'b0;
        end else begin
            state       <= state_n;
            div         <= div_n;
            quarter     <= quarter_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            o_scl       <= scl_n;
            o_sda       <= sda_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_ack_err   <= ack_err_n;
            o_cmd_err   <= cmd_err_n;
            o_bus_owned <= owned_n;
        end
    end

    // Commands are only looked at while parked; start beats send beats stop.
    always_comb begin
        state_n   = state;
        div_n     = div;
        quarter_n = quarter;
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        ack_err_n = o_ack_err;
        owned_n   = o_bus_owned;
        done_n    = 1'b0;
        cmd_err_n = 1'b0;
        case (state)
            IDLE, HOLD: begin
                div_n     = '0;
                quarter_n = '0;
                if (i_i2c_start) begin
                    state_n = START;
                end else if (i_sendi2c) begin
                    if (state == HOLD) begin
                        state_n = BIT;
                        shreg_n = i_data;
                        bit_n   = 3'd7;
                    end else begin
                        cmd_err_n = 1'b1;
                    end
                end else if (i_i2c_stop) begin
                    if (state == HOLD) state_n = STOP;
                    else cmd_err_n = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    div_n     = '0;
                    quarter_n = quarter + 2'd1;
                    if (state == ACK && quarter == 2'd2) ack_err_n = i_sda;
                    if (quarter == 2'd3) begin
                        case (state)
                            START: begin
                                state_n   = HOLD;
                                owned_n   = 1'b1;
                                ack_err_n = 1'b0;
                                done_n    = 1'b1;
                            end
                            BIT: begin
                                if (bit_cnt == 3'd0) state_n = ACK;
                                else bit_n = bit_cnt - 3'd1;
                            end
                            ACK: begin
                                state_n = HOLD;
                                done_n  = 1'b1;
                            end
                            default: begin
                                state_n = IDLE;
                                owned_n = 1'b0;
                                done_n  = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    div_n = div + DW'(1);
                end
            end
        endcase
    end

    // Line levels are decoded from the upcoming state so the pins come straight off flops.
    always_comb begin
        scl_n  = 1'b1;
        sda_n  = 1'b1;
        busy_n = !(state_n == IDLE || state_n == HOLD);
        case (state_n)
            IDLE: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
            HOLD: begin
                scl_n = 1'b0;
                sda_n = 1'b0;
            end
            START: begin
                scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
                sda_n = (quarter_n == 2'd0) || (quarter_n == 2'd1);
            end
            BIT: begin
                scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
                sda_n = shreg_n[bit_n];
            end
            ACK: begin
                scl_n = (quarter_n == 2'd1) || (quarter_n == 2'd2);
                sda_n = 1'b1;
            end
            STOP: begin
                scl_n = (quarter_n != 2'd0);
                sda_n = quarter_n[1];
            end
            default: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Randomised scoreboard bench for i2c_master_tx: the stimulus side predicts each
// completion event from bus-level rules, a monitor watches the pins and checks them.
module tb_i2c_master_tx;

    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_i2c_start, i_i2c_stop, i_sendi2c;
    logic [7:0] i_data;
    logic       i_sda;
    logic       o_scl, o_sda, o_busy, o_done, o_ack_err, o_cmd_err, o_bus_owned;

    i2c_master_tx #(.CLK_DIV(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_i2c_start(i_i2c_start), .i_i2c_stop(i_i2c_stop), .i_sendi2c(i_sendi2c),
        .i_data(i_data), .i_sda(i_sda),
        .o_scl(o_scl), .o_sda(o_sda), .o_busy(o_busy), .o_done(o_done),
        .o_ack_err(o_ack_err), .o_cmd_err(o_cmd_err), .o_bus_owned(o_bus_owned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int kind;     // 0 = done, 1 = cmd_err
        int busy;
        int owned;
        int ack;
        int scl;
        int sda;
        int nedges;
        int edges;    // SDA values seen at SCL rising edges, first edge most significant
        int starts;
        int stops;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    bit   m_owned = 1'b0;
    bit   m_ack   = 1'b0;

    task automatic check_output(input string name, input int act, input int req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_scl"}, int'(o_scl), 1);
        check_output({tag, "_sda"}, int'(o_sda), 1);
        check_output({tag, "_busy"}, int'(o_busy), 0);
        check_output({tag, "_owned"}, int'(o_bus_owned), 0);
        check_output({tag, "_ack_err"}, int'(o_ack_err), 0);
        check_output({tag, "_done"}, int'(o_done), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) check_output("busy_timeout", 1, 0);
    endtask

    // Predict the outcome from bus ownership, then pulse the command for one cycle.
    task automatic apply_stimulus(input bit st, input bit sd, input bit sp,
                                  input logic [7:0] data, input bit nack);
        exp_t e;
        wait_idle();
        e = '{kind: 0, busy: 0, owned: 0, ack: 0, scl: 0, sda: 0,
              nedges: 0, edges: 0, starts: 0, stops: 0};
        if (st) begin
            m_owned = 1'b1;
            m_ack   = 1'b0;
            e.busy = 4 * D; e.nedges = 1; e.edges = 1; e.starts = 1;
        end else if (sd) begin
            if (m_owned) begin
                m_ack  = nack;
                e.busy = 36 * D; e.nedges = 9; e.edges = (int'(data) * 2) + 1;
            end else begin
                e.kind = 1;
            end
        end else if (sp) begin
            if (m_owned) begin
                m_owned = 1'b0;
                e.busy = 4 * D; e.nedges = 1; e.edges = 0; e.stops = 1;
            end else begin
                e.kind = 1;
            end
        end
        e.owned = int'(m_owned);
        e.ack   = int'(m_ack);
        e.scl   = m_owned ? 0 : 1;
        e.sda   = m_owned ? 0 : 1;
        if (st || sd || sp) exp_q.push_back(e);
        @(negedge i_clk);
        i_i2c_start = st;
        i_sendi2c   = sd;
        i_i2c_stop  = sp;
        i_data      = data;
        i_sda       = nack;
        @(negedge i_clk);
        i_i2c_start = 1'b0;
        i_sendi2c   = 1'b0;
        i_i2c_stop  = 1'b0;
        i_data      = 8'($urandom);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        m_owned = 1'b0;
        m_ack   = 1'b0;
        check_reset_state(tag);
    endtask

    // Monitor: tracks bus conditions and busy time, checks each done/cmd_err against the queue.
    initial begin
        int   busy_cnt = 0, starts = 0, stops = 0, nedges = 0, edges = 0;
        logic prev_scl = 1'b1, prev_sda = 1'b1;
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                exp_q.delete();
                busy_cnt = 0; starts = 0; stops = 0; nedges = 0; edges = 0;
                prev_scl = 1'b1; prev_sda = 1'b1;
            end else begin
                if (o_busy) busy_cnt++;
                if (o_scl && prev_scl && prev_sda && !o_sda) starts++;
                if (o_scl && prev_scl && !prev_sda && o_sda) stops++;
                if (o_scl && !prev_scl) begin
                    edges = (edges * 2) + int'(o_sda);
                    nedges++;
                end
                if (o_done || o_cmd_err) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_event", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("event_kind", o_cmd_err ? 1 : 0, e.kind);
                        check_output("busy_cycles", busy_cnt, e.busy);
                        check_output("bus_owned", int'(o_bus_owned), e.owned);
                        check_output("ack_err", int'(o_ack_err), e.ack);
                        check_output("scl_after", int'(o_scl), e.scl);
                        check_output("sda_after", int'(o_sda), e.sda);
                        check_output("scl_rises", nedges, e.nedges);
                        check_output("sda_at_rises", edges, e.edges);
                        check_output("start_conds", starts, e.starts);
                        check_output("stop_conds", stops, e.stops);
                    end
                    busy_cnt = 0; starts = 0; stops = 0; nedges = 0; edges = 0;
                end
                prev_scl = o_scl;
                prev_sda = o_sda;
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        i_i2c_start = 1'b0; i_i2c_stop = 1'b0; i_sendi2c = 1'b0;
        i_data = 8'h00; i_sda = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_state("por");

        apply_stimulus(1, 0, 0, 8'h00, 0);
        apply_stimulus(0, 1, 0, 8'hA5, 0);
        apply_stimulus(0, 1, 0, 8'h3C, 1);
        apply_stimulus(0, 0, 1, 8'h00, 0);
        apply_stimulus(0, 1, 0, 8'h12, 0);
        apply_stimulus(0, 0, 1, 8'h00, 0);
        apply_stimulus(1, 1, 0, 8'h55, 0);
        apply_stimulus(1, 0, 0, 8'h00, 1);
        apply_stimulus(0, 1, 1, 8'hFF, 0);
        apply_stimulus(0, 0, 1, 8'h00, 0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(1, 7));
            apply_stimulus(c[0], c[1], c[2], 8'($urandom), 1'($urandom));
        end

        if (!m_owned) apply_stimulus(1, 0, 0, 8'h00, 0);
        apply_stimulus(0, 1, 0, 8'h96, 0);
        repeat (4 * D * 3 + 8) @(negedge i_clk);
        pulse_reset("midbyte_rst");
        apply_stimulus(1, 0, 0, 8'h00, 0);
        apply_stimulus(0, 1, 0, 8'hC3, 1);
        apply_stimulus(0, 0, 1, 8'h00, 0);

        wait_idle();
        repeat (4) @(negedge i_clk);
        check_output("pending_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
